// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard scoreboard.
//   div_state_e  : divide-unit occupancy states
//   DEF_CW       : default pending-counter width
//   DEF_CNT_MAX  : saturation value of a default-width counter
//   unpack_addr  : extracts operand idx (aw bits wide) from a packed address bus
package hazard_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_e;

    localparam int DEF_CW      = 2;
    localparam int DEF_CNT_MAX = (1 << DEF_CW) - 1;

    // Wide enough for any sensible NSRC*AW; callers zero-extend into it.
    localparam int UNPACK_W = 1024;

    function automatic logic [31:0] unpack_addr(input logic [UNPACK_W-1:0] vec,
                                                input int unsigned idx,
                                                input int unsigned aw);
        logic [UNPACK_W-1:0] mask;
        mask = (UNPACK_W'(1) << aw) - UNPACK_W'(1);
        return 32'((vec >> (idx * aw)) & mask);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_div_tracker.sv
// Divide-unit occupancy tracker.
// Ports:
//   clk, rst, flush          : clock, synchronous reset, exception flush
//   issue_valid, issue_div   : instruction in D wants the divider
//   issue_wen, issue_waddr   : its destination (0 latched when it writes nothing)
//   accept                   : the instruction in D advances this cycle
//   div_busy                 : FSM not IDLE
//   div_done                 : result write-back pulse (DONE state only)
//   div_waddr                : destination of the divide in flight
//   struct_stall             : a divide in D must wait for the unit
module div_tracker
    import hazard_pkg::*;
#(
    parameter int AW      = 5,
    parameter int DIV_LAT = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          issue_valid,
    input  logic          issue_div,
    input  logic          issue_wen,
    input  logic [AW-1:0] issue_waddr,
    input  logic          accept,
    output logic          div_busy,
    output logic          div_done,
    output logic [AW-1:0] div_waddr,
    output logic          struct_stall
);

    // BUSY lasts DIV_LAT-1 cycles, DONE one more: accept-to-pulse = DIV_LAT.
    localparam int LW = (DIV_LAT > 2) ? $clog2(DIV_LAT - 1) : 1;
    localparam logic [LW-1:0] LAT_LOAD = LW'(DIV_LAT - 2);

    div_state_e    state_reg, state_next;
    logic [LW-1:0] lat_reg, lat_next;
    logic [AW-1:0] waddr_reg, waddr_next;
    logic          start;

    assign start = accept & issue_div;

    always_comb begin
        state_next = state_reg;
        lat_next   = lat_reg;
        waddr_next = waddr_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = BUSY;
                    lat_next   = LAT_LOAD;
                    waddr_next = issue_wen ? issue_waddr : '0;
                end
            end
            BUSY: begin
                if (lat_reg == '0) begin
                    state_next = DONE;
                end else begin
                    lat_next = lat_reg - LW'(1);
                end
            end
            DONE: begin
                // Back-to-back: a new divide may enter in the write-back cycle.
                if (start) begin
                    state_next = BUSY;
                    lat_next   = LAT_LOAD;
                    waddr_next = issue_wen ? issue_waddr : '0;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            lat_reg   <= '0;
            waddr_reg <= '0;
        end else if (flush) begin
            state_reg <= IDLE;
            lat_reg   <= '0;
        end else begin
            state_reg <= state_next;
            lat_reg   <= lat_next;
            waddr_reg <= waddr_next;
        end
    end

    // A killed divide must not write back, even if it sits in DONE.
    assign div_done     = (state_reg == DONE) & ~flush & ~rst;
    assign div_busy     = (state_reg != IDLE);
    assign div_waddr    = waddr_reg;
    assign struct_stall = issue_valid & issue_div & (state_reg == BUSY);

endmodule

// File: rtl/hazard_scoreboard.sv
// Stateful RAW/structural hazard scoreboard at the D->E boundary.
// Per-register saturating counters track outstanding long-latency writes;
// the divider's occupancy lives in div_tracker.
// Ports:
//   clk, rst, flush                : clock, synchronous reset, exception flush
//   issue_*                        : instruction in D (valid, write enable/addr, long, div)
//   src_valid, src_addr            : NSRC operand reads, operand i at [i*AW +: AW]
//   cpl_valid, cpl_addr            : external long-result write-back
//   stall, raw_stall               : decode stall and its RAW component
//   div_busy, div_done, div_waddr  : divider status
//   pending_vec                    : bit r set while register r has writes outstanding
//   overflow_err                   : sticky, increment hit a saturated counter
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NREG    = 32,
    parameter int AW      = 5,
    parameter int NSRC    = 2,
    parameter int CW      = DEF_CW,
    parameter int DIV_LAT = 32,
    parameter int BYPASS  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             issue_valid,
    input  logic             issue_wen,
    input  logic [AW-1:0]    issue_waddr,
    input  logic             issue_long,
    input  logic             issue_div,
    input  logic [NSRC-1:0]  src_valid,
    input  logic [NSRC*AW-1:0] src_addr,
    input  logic             cpl_valid,
    input  logic [AW-1:0]    cpl_addr,
    output logic             stall,
    output logic             raw_stall,
    output logic             div_busy,
    output logic             div_done,
    output logic [AW-1:0]    div_waddr,
    output logic [NREG-1:0]  pending_vec,
    output logic             overflow_err
);

    localparam int NADDR = 1 << AW;
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [NREG-1:0][CW-1:0] cnt_reg, cnt_next;
    logic [NREG-1:0]         ovf_hit, one_vec;
    logic [NADDR-1:0]        pend_full, one_full;
    logic [NSRC-1:0]         src_hit;
    logic [UNPACK_W-1:0]     src_pad;
    logic                    overflow_err_reg;
    logic                    accept, struct_stall, inc_en;

    div_tracker #(
        .AW      (AW),
        .DIV_LAT (DIV_LAT)
    ) u_div (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .issue_valid  (issue_valid),
        .issue_div    (issue_div),
        .issue_wen    (issue_wen),
        .issue_waddr  (issue_waddr),
        .accept       (accept),
        .div_busy     (div_busy),
        .div_done     (div_done),
        .div_waddr    (div_waddr),
        .struct_stall (struct_stall)
    );

    assign accept = issue_valid & ~stall;
    assign inc_en = accept & (issue_long | issue_div) & issue_wen & (issue_waddr != '0);

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_cnt
            logic          inc, dec_cpl, dec_div;
            logic [CW+1:0] sum;
            assign inc     = inc_en & (issue_waddr == AW'(gi));
            assign dec_cpl = cpl_valid & (cpl_addr == AW'(gi)) & (cpl_addr != '0);
            assign dec_div = div_done & (div_waddr == AW'(gi));
            // Two spare bits: bit CW flags above max, bit CW+1 flags below zero.
            assign sum = {2'b00, cnt_reg[gi]} + (CW+2)'(inc)
                         - (CW+2)'(dec_cpl) - (CW+2)'(dec_div);
            assign cnt_next[gi] = sum[CW+1] ? '0 : (sum[CW] ? CNT_MAX : sum[CW-1:0]);
            assign ovf_hit[gi]     = inc & (cnt_reg[gi] == CNT_MAX);
            assign pending_vec[gi] = |cnt_reg[gi];
            assign one_vec[gi]     = (cnt_reg[gi] == CW'(1));
        end
    endgenerate

    // Full address-space views so any AW-bit operand indexes safely.
    assign pend_full = NADDR'(pending_vec);
    assign one_full  = NADDR'(one_vec);
    assign src_pad   = UNPACK_W'(src_addr);

    generate
        for (gi = 0; gi < NSRC; gi++) begin : g_src
            logic [AW-1:0] sa;
            logic          byp;
            assign sa  = AW'(unpack_addr(src_pad, gi, AW));
            // Only the last outstanding write can be bypassed by its own completion.
            assign byp = (BYPASS != 0)
                       & ((cpl_valid & (cpl_addr == sa)) | (div_done & (div_waddr == sa)))
                       & one_full[sa];
            assign src_hit[gi] = src_valid[gi] & (sa != '0) & pend_full[sa] & ~byp;
        end
    endgenerate

    assign raw_stall    = |src_hit;
    assign stall        = raw_stall | struct_stall;
    assign overflow_err = overflow_err_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg          <= '0;
            overflow_err_reg <= 1'b0;
        end else if (flush) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
            if (|ovf_hit) begin
                overflow_err_reg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: a vector table for the single-cycle
// behaviour, then hand-written divide / flush / reset sequences.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic        issue_valid, issue_wen, issue_long, issue_div;
    logic [4:0]  issue_waddr;
    logic [1:0]  src_valid;
    logic [9:0]  src_addr;
    logic        cpl_valid;
    logic [4:0]  cpl_addr;
    logic        stall, raw_stall, div_busy, div_done;
    logic [4:0]  div_waddr;
    logic [31:0] pending_vec;
    logic        overflow_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .issue_valid  (issue_valid),
        .issue_wen    (issue_wen),
        .issue_waddr  (issue_waddr),
        .issue_long   (issue_long),
        .issue_div    (issue_div),
        .src_valid    (src_valid),
        .src_addr     (src_addr),
        .cpl_valid    (cpl_valid),
        .cpl_addr     (cpl_addr),
        .stall        (stall),
        .raw_stall    (raw_stall),
        .div_busy     (div_busy),
        .div_done     (div_done),
        .div_waddr    (div_waddr),
        .pending_vec  (pending_vec),
        .overflow_err (overflow_err)
    );

    typedef struct {
        logic       iv, wen, lng;
        logic [4:0] wa;
        logic [1:0] sv;
        logic [4:0] s0, s1;
        logic       cv;
        logic [4:0] ca;
        logic       e_stall;
        logic [31:0] e_pend;
        logic       e_ovf;
    } vec_t;

    function automatic vec_t mk(logic iv, logic wen, logic [4:0] wa, logic lng,
                                logic [1:0] sv, logic [4:0] s0, logic [4:0] s1,
                                logic cv, logic [4:0] ca,
                                logic es, logic [31:0] ep, logic eo);
        vec_t v;
        v.iv = iv; v.wen = wen; v.wa = wa; v.lng = lng;
        v.sv = sv; v.s0 = s0; v.s1 = s1; v.cv = cv; v.ca = ca;
        v.e_stall = es; v.e_pend = ep; v.e_ovf = eo;
        return v;
    endfunction

    function automatic logic [31:0] bitv(int n);
        return 32'h1 << n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        flush = 0; issue_valid = 0; issue_wen = 0; issue_long = 0; issue_div = 0;
        issue_waddr = 0; src_valid = 0; src_addr = 0; cpl_valid = 0; cpl_addr = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
    endtask

    task automatic drive_issue(logic lng, logic dv, logic [4:0] wa);
        @(negedge clk);
        clear_inputs();
        issue_valid = 1; issue_wen = 1; issue_long = lng; issue_div = dv; issue_waddr = wa;
    endtask

    vec_t tbl[28];
    logic [31:0] ep;

    initial begin
        tbl[0]  = mk(0,0, 0,0, 0, 0, 0, 0, 0, 0, 0,        0);
        tbl[1]  = mk(1,1, 5,1, 0, 0, 0, 0, 0, 0, 0,        0);
        tbl[2]  = mk(1,0, 0,0, 1, 5, 0, 0, 0, 1, bitv(5),  0);
        tbl[3]  = mk(1,0, 0,0, 1, 5, 0, 0, 0, 1, bitv(5),  0);
        tbl[4]  = mk(1,0, 0,0, 1, 5, 0, 1, 5, 0, bitv(5),  0);
        tbl[5]  = mk(0,0, 0,0, 0, 0, 0, 0, 0, 0, 0,        0);
        tbl[6]  = mk(1,1, 0,1, 3, 0, 0, 0, 0, 0, 0,        0);
        tbl[7]  = mk(0,0, 0,0, 0, 0, 0, 0, 0, 0, 0,        0);
        tbl[8]  = mk(1,1, 7,1, 0, 0, 0, 0, 0, 0, 0,        0);
        tbl[9]  = mk(1,1, 7,1, 0, 0, 0, 1, 7, 0, bitv(7),  0);
        tbl[10] = mk(1,0, 0,0, 2, 0, 7, 0, 0, 1, bitv(7),  0);
        tbl[11] = mk(1,0, 0,0, 2, 0, 7, 1, 7, 0, bitv(7),  0);
        tbl[12] = mk(0,0, 0,0, 0, 0, 0, 0, 0, 0, 0,        0);
        tbl[13] = mk(1,1, 3,1, 0, 0, 0, 0, 0, 0, 0,        0);
        tbl[14] = mk(1,1, 3,1, 0, 0, 0, 0, 0, 0, bitv(3),  0);
        tbl[15] = mk(1,1, 3,1, 0, 0, 0, 0, 0, 0, bitv(3),  0);
        tbl[16] = mk(1,1, 3,1, 0, 0, 0, 0, 0, 0, bitv(3),  0);
        tbl[17] = mk(0,0, 0,0, 0, 0, 0, 1, 3, 0, bitv(3),  1);
        tbl[18] = mk(1,0, 0,0, 1, 3, 0, 1, 3, 1, bitv(3),  1);
        tbl[19] = mk(1,0, 0,0, 1, 3, 0, 1, 3, 0, bitv(3),  1);
        tbl[20] = mk(0,0, 0,0, 0, 0, 0, 0, 0, 0, 0,        1);
        tbl[21] = mk(0,0, 0,0, 0, 0, 0, 1, 3, 0, 0,        1);
        tbl[22] = mk(0,0, 0,0, 0, 0, 0, 0, 0, 0, 0,        1);
        tbl[23] = mk(1,1,12,1, 0, 0, 0, 0, 0, 0, 0,        1);
        tbl[24] = mk(1,0, 0,0, 0,12, 0, 0, 0, 0, bitv(12), 1);
        tbl[25] = mk(1,1, 9,1, 2, 0,12, 0, 0, 1, bitv(12), 1);
        tbl[26] = mk(0,0, 0,0, 0, 0, 0, 1,12, 0, bitv(12), 1);
        tbl[27] = mk(0,0, 0,0, 0, 0, 0, 0, 0, 0, 0,        1);

        do_reset();

        // Table: inputs held for one cycle, outputs checked before the edge.
        for (int i = 0; i < 28; i++) begin
            @(negedge clk);
            clear_inputs();
            issue_valid = tbl[i].iv; issue_wen = tbl[i].wen; issue_waddr = tbl[i].wa;
            issue_long = tbl[i].lng; src_valid = tbl[i].sv; src_addr = {tbl[i].s1, tbl[i].s0};
            cpl_valid = tbl[i].cv; cpl_addr = tbl[i].ca;
            #1;
            chk($sformatf("vec%0d_stall", i), 32'(stall), 32'(tbl[i].e_stall));
            chk($sformatf("vec%0d_raw", i), 32'(raw_stall), 32'(tbl[i].e_stall));
            chk($sformatf("vec%0d_pend", i), pending_vec, tbl[i].e_pend);
            chk($sformatf("vec%0d_ovf", i), 32'(overflow_err), 32'(tbl[i].e_ovf));
            chk($sformatf("vec%0d_busy", i), 32'(div_busy), 32'd0);
            chk($sformatf("vec%0d_done", i), 32'(div_done), 32'd0);
            $display("[TB] vec %0d stall=%0b pend=%08h ovf=%0b", i, stall, pending_vec, overflow_err);
        end

        // Divide r8, second divide to r10 waits and enters back-to-back.
        do_reset();
        chk("divA_rst_ovf", 32'(overflow_err), 32'd0);
        drive_issue(0, 1, 5'd8);
        #1 chk("divA_acc_stall", 32'(stall), 32'd0);
        for (int k = 1; k <= 66; k++) begin
            @(negedge clk);
            clear_inputs();
            if (k >= 5 && k <= 32) begin
                issue_valid = 1; issue_div = 1; issue_wen = 1; issue_waddr = 5'd10;
            end
            #1;
            ep = ((k <= 32) ? bitv(8) : 32'h0) | ((k >= 33 && k <= 64) ? bitv(10) : 32'h0);
            chk($sformatf("divA_busy_k%0d", k), 32'(div_busy), 32'(k <= 64));
            chk($sformatf("divA_done_k%0d", k), 32'(div_done), 32'(k == 32 || k == 64));
            chk($sformatf("divA_stall_k%0d", k), 32'(stall), 32'(k >= 5 && k <= 31));
            chk($sformatf("divA_pend_k%0d", k), pending_vec, ep);
            if (k <= 64)
                chk($sformatf("divA_waddr_k%0d", k), 32'(div_waddr), (k <= 32) ? 32'd8 : 32'd10);
            $display("[TB] divA k=%0d busy=%0b done=%0b stall=%0b pend=%08h", k, div_busy, div_done, stall, pending_vec);
        end

        // Flush mid-divide with r4, r9 pending; late completion on r4 ignored.
        do_reset();
        drive_issue(1, 0, 5'd4);
        drive_issue(1, 0, 5'd9);
        drive_issue(0, 1, 5'd20);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            clear_inputs();
            if (k == 10) flush = 1;
            if (k == 35) begin cpl_valid = 1; cpl_addr = 5'd4; end
            #1;
            ep = (k <= 10) ? (bitv(4) | bitv(9) | bitv(20)) : 32'h0;
            chk($sformatf("flush_busy_k%0d", k), 32'(div_busy), 32'(k <= 10));
            chk($sformatf("flush_done_k%0d", k), 32'(div_done), 32'd0);
            chk($sformatf("flush_pend_k%0d", k), pending_vec, ep);
            $display("[TB] flush k=%0d busy=%0b done=%0b pend=%08h", k, div_busy, div_done, pending_vec);
        end

        // Flush landing exactly in the DONE cycle suppresses the pulse.
        do_reset();
        drive_issue(0, 1, 5'd1);
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            clear_inputs();
            if (k == 32) flush = 1;
            #1;
            chk($sformatf("flushd_busy_k%0d", k), 32'(div_busy), 32'(k <= 32));
            chk($sformatf("flushd_done_k%0d", k), 32'(div_done), 32'd0);
            chk($sformatf("flushd_pend_k%0d", k), pending_vec, (k <= 32) ? bitv(1) : 32'h0);
            $display("[TB] flushd k=%0d busy=%0b done=%0b pend=%08h", k, div_busy, div_done, pending_vec);
        end

        // Reset mid-BUSY with loads pending and overflow set.
        do_reset();
        repeat (4) drive_issue(1, 0, 5'd2);
        drive_issue(0, 1, 5'd6);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            clear_inputs();
            if (k == 3) rst = 1;
            if (k == 4) begin
                rst = 0; issue_valid = 1; src_valid = 2'b01; src_addr = {5'd0, 5'd2};
            end
            #1;
            if (k == 2) begin
                chk("rstC_pre_ovf", 32'(overflow_err), 32'd1);
                chk("rstC_pre_pend", pending_vec, bitv(2) | bitv(6));
                chk("rstC_pre_busy", 32'(div_busy), 32'd1);
                chk("rstC_pre_waddr", 32'(div_waddr), 32'd6);
            end
            if (k == 4) begin
                chk("rstC_pend", pending_vec, 32'h0);
                chk("rstC_busy", 32'(div_busy), 32'd0);
                chk("rstC_done", 32'(div_done), 32'd0);
                chk("rstC_waddr", 32'(div_waddr), 32'd0);
                chk("rstC_ovf", 32'(overflow_err), 32'd0);
                chk("rstC_stall", 32'(stall), 32'd0);
                chk("rstC_raw", 32'(raw_stall), 32'd0);
            end
            $display("[TB] rstC k=%0d busy=%0b ovf=%0b pend=%08h", k, div_busy, overflow_err, pending_vec);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
